// File: rtl/axil_ram_slave.sv
// AXI-Lite slave backed by a word-organised register-array memory with independent read/write FSMs.
// Optional macro AXIL_RAM_SLAVE_ERR_EN: out-of-range addresses answer SLVERR instead of aliasing.
module axil_ram_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready
);

   localparam int ADDR_LSB = $clog2(STRB_WIDTH);
   localparam int IDX_MSB  = DEPTH_LOG2 + ADDR_LSB - 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

   w_state_e              w_state_q;
   logic                  aw_held_q, w_held_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;

   r_state_e              r_state_q;
   logic                  rvalid_q;
   logic [1:0]            rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  aw_hs, w_hs, ar_hs, wr_commit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
   logic                  wr_oor, rd_oor;
   logic                  unused_bits;

   // Readies come from state and held flags only; rst forces them low for the reset cycle itself.
   assign s_axil_awready = !rst && (w_state_q == W_IDLE) && !aw_held_q;
   assign s_axil_wready  = !rst && (w_state_q == W_IDLE) && !w_held_q;
   assign s_axil_arready = !rst && (r_state_q == R_IDLE);

   assign aw_hs = s_axil_awvalid && s_axil_awready;
   assign w_hs  = s_axil_wvalid  && s_axil_wready;
   assign ar_hs = s_axil_arvalid && s_axil_arready;

   assign wr_addr = aw_held_q ? awaddr_q : s_axil_awaddr;
   assign wr_data = w_held_q  ? wdata_q  : s_axil_wdata;
   assign wr_strb = w_held_q  ? wstrb_q  : s_axil_wstrb;
   assign wr_commit = !rst && (w_state_q == W_IDLE)
                      && (aw_held_q || aw_hs) && (w_held_q || w_hs);

   assign wr_idx = wr_addr[IDX_MSB:ADDR_LSB];
   assign rd_idx = s_axil_araddr[IDX_MSB:ADDR_LSB];

`ifdef AXIL_RAM_SLAVE_ERR_EN
   assign wr_oor = |wr_addr[ADDR_WIDTH-1:IDX_MSB+1];
   assign rd_oor = |s_axil_araddr[ADDR_WIDTH-1:IDX_MSB+1];
`else
   assign wr_oor = 1'b0;
   assign rd_oor = 1'b0;
`endif

   assign unused_bits = ^{s_axil_awprot, s_axil_arprot, wr_addr, s_axil_araddr};

   assign s_axil_bvalid = bvalid_q;
   assign s_axil_bresp  = bresp_q;
   assign s_axil_rvalid = rvalid_q;
   assign s_axil_rresp  = rresp_q;
   assign s_axil_rdata  = rdata_q;

   // NOTE: the array has no reset branch so it maps onto plain storage; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (wr_commit && !wr_oor) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         unique case (w_state_q)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_held_q <= 1'b1;
                  awaddr_q  <= s_axil_awaddr;
               end
               if (w_hs) begin
                  w_held_q <= 1'b1;
                  wdata_q  <= s_axil_wdata;
                  wstrb_q  <= s_axil_wstrb;
               end
               if (wr_commit) begin
                  aw_held_q <= 1'b0;
                  w_held_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_oor ? RESP_SLVERR : RESP_OKAY;
                  w_state_q <= W_RESP;
               end
            end
            W_RESP: begin
               if (s_axil_bready) begin
                  bvalid_q  <= 1'b0;
                  w_state_q <= W_IDLE;
               end
            end
         endcase
      end
   end

   // NOTE: non-blocking reads of mem_q see the pre-edge word, which gives read-before-write on a shared edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
      end else begin
         unique case (r_state_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata_q   <= rd_oor ? '0 : mem_q[rd_idx];
                  rresp_q   <= rd_oor ? RESP_SLVERR : RESP_OKAY;
                  rvalid_q  <= 1'b1;
                  r_state_q <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axil_rready) begin
                  rvalid_q  <= 1'b0;
                  r_state_q <= R_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Randomised self-checking bench for axil_ram_slave with a transaction-level reference model.
// Honours AXIL_RAM_SLAVE_ERR_EN the same way the design does.
module tb_axil_ram_slave;

`ifdef AXIL_RAM_SLAVE_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic [2:0]  prot = 3'b000;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   always #5 clk = ~clk;

   axil_ram_slave dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(awaddr), .s_axil_awprot(prot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arprot(prot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: pending AW/W payloads, outstanding responses, and a byte-known memory image.
   logic [31:0] m_mem   [1024];
   logic [31:0] m_known [1024];
   bit          m_aw = 0, m_w = 0, m_b = 0, m_r = 0;
   logic [31:0] m_awaddr, m_wdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
   logic [31:0] m_rdata = '0, m_rmask = '1;

   function automatic bit oor(input logic [31:0] a);
      return ERR_EN && ((a >> 12) != 0);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) & 32'h3FF);
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) m_known[i] = '0;
      forever begin
         @(negedge clk);
         begin
            bit e_awr, e_wr, e_arr, awf, wf, arf;
            int i;
            e_awr = !rst && !m_b && !m_aw;
            e_wr  = !rst && !m_b && !m_w;
            e_arr = !rst && !m_r;
            check("awready", awready, e_awr);
            check("wready", wready, e_wr);
            check("arready", arready, e_arr);
            check("bvalid", bvalid, m_b);
            check("bresp", bresp, m_bresp);
            check("rvalid", rvalid, m_r);
            check("rresp", rresp, m_rresp);
            check("rdata", rdata & m_rmask, m_rdata & m_rmask);
            if (rst) begin
               m_aw = 0; m_w = 0; m_b = 0; m_r = 0;
               m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_rmask = '1;
            end else begin
               awf = awvalid && e_awr;
               wf  = wvalid && e_wr;
               arf = arvalid && e_arr;
               if (m_b && bready) m_b = 0;
               if (m_r && rready) m_r = 0;
               if (arf) begin
                  m_r = 1;
                  if (oor(araddr)) begin
                     m_rdata = '0; m_rmask = '1; m_rresp = 2'b10;
                  end else begin
                     m_rdata = m_mem[widx(araddr)]; m_rmask = m_known[widx(araddr)]; m_rresp = 2'b00;
                  end
               end
               if (awf) begin m_aw = 1; m_awaddr = awaddr; end
               if (wf)  begin m_w = 1; m_wdata = wdata; m_wstrb = wstrb; end
               if (m_aw && m_w) begin
                  m_aw = 0; m_w = 0; m_b = 1;
                  m_bresp = oor(m_awaddr) ? 2'b10 : 2'b00;
                  if (!oor(m_awaddr)) begin
                     i = widx(m_awaddr);
                     for (int b = 0; b < 4; b++) begin
                        if (m_wstrb[b]) begin
                           m_mem[i][8*b +: 8]   = m_wdata[8*b +: 8];
                           m_known[i][8*b +: 8] = 8'hFF;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   // Driver side: handshake flags observed on the previous cycle.
   bit          aw_f, w_f, b_f, ar_f, r_f;
   logic [31:0] got_rdata;
   logic [1:0]  got_rresp, got_bresp;

   task automatic tick();
      @(negedge clk);
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      b_f  = bvalid && bready;
      ar_f = arvalid && arready;
      r_f  = rvalid && rready;
      if (r_f) begin got_rdata = rdata; got_rresp = rresp; end
      if (b_f) got_bresp = bresp;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, output logic [1:0] resp);
      int n = 0;
      bit done = 0;
      awaddr = a; wdata = d; wstrb = s;
      wvalid = 1; awvalid = (w_lead == 0); bready = 1;
      while (!done && n < 50) begin
         tick();
         n++;
         if (w_f) wvalid = 0;
         if (aw_f) awvalid = 0;
         if (b_f) done = 1;
         if (n == w_lead) awvalid = 1;
      end
      check("write done", done, 1);
      awvalid = 0; wvalid = 0; bready = 0;
      resp = got_bresp;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      bit done = 0;
      araddr = a; arvalid = 1; rready = 1;
      while (!done && n < 50) begin
         tick();
         n++;
         if (ar_f) arvalid = 0;
         if (r_f) done = 1;
      end
      check("read done", done, 1);
      arvalid = 0; rready = 0;
      d = got_rdata; r = got_rresp;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      return a;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d, first_rd, second_rd;
      logic [1:0]  r, resp;
      int          rd_n, b_n, acc_n;

      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Basic write/read.
      do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, resp);
      check("t1 bresp", resp, 2'b00);
      do_read(32'h10, d, r);
      check("t1 rdata", d, 32'hDEADBEEF);
      check("t1 rresp", r, 2'b00);

      // W leads AW by three cycles.
      do_write(32'h20, 32'h12345678, 4'hF, 3, resp);
      do_read(32'h20, d, r);
      check("t2 rdata", d, 32'h12345678);

      // Byte strobes.
      do_write(32'h4, 32'hAABBCCDD, 4'hF, 0, resp);
      do_write(32'h4, 32'h00000011, 4'h1, 0, resp);
      do_read(32'h4, d, r);
      check("t3 rdata", d, 32'hAABBCC11);
      check("t3 model word1", m_mem[1], 32'hAABBCC11);

      // Back-pressure on B and R with new requests waiting.
      awaddr = 32'h30; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      araddr = 32'h10; arvalid = 1; rready = 0;
      tick();
      check("t4 first accept", {aw_f, w_f, ar_f}, 3'b111);
      awaddr = 32'h34; wdata = 32'h66; araddr = 32'h20;
      acc_n = 0;
      repeat (5) begin
         tick();
         if (aw_f || w_f || ar_f) acc_n++;
      end
      check("t4 stalled accepts", acc_n, 0);
      bready = 1; rready = 1;
      rd_n = 0; b_n = 0; first_rd = '0; second_rd = '0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (aw_f) awvalid = 0;
         if (w_f) wvalid = 0;
         if (ar_f) arvalid = 0;
         if (b_f) b_n++;
         if (r_f) begin
            rd_n++;
            if (rd_n == 1) first_rd = got_rdata;
            if (rd_n == 2) second_rd = got_rdata;
         end
      end
      bready = 0; rready = 0;
      check("t4 b count", b_n, 2);
      check("t4 r count", rd_n, 2);
      check("t4 first rdata", first_rd, 32'hDEADBEEF);
      check("t4 second rdata", second_rd, 32'h12345678);

      // Same-edge write and read to one word.
      do_write(32'h8, 32'h1, 4'hF, 0, resp);
      awaddr = 32'h8; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
      araddr = 32'h8; arvalid = 1; rready = 1;
      tick();
      check("t5 same edge accept", {aw_f, w_f, ar_f}, 3'b111);
      awvalid = 0; wvalid = 0; arvalid = 0;
      rd_n = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (r_f) begin rd_n++; first_rd = got_rdata; end
      end
      bready = 0; rready = 0;
      check("t5 r count", rd_n, 1);
      check("t5 old data", first_rd, 32'h1);
      do_read(32'h8, d, r);
      check("t5 new data", d, 32'h5);

      // Out-of-range / aliasing access.
      do_write(32'h0, 32'h0BADF00D, 4'hF, 0, resp);
      do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0, resp);
      check("t6 bresp", resp, ERR_EN ? 2'b10 : 2'b00);
      do_read(32'h1000, d, r);
      check("t6 rdata", d, ERR_EN ? 32'h0 : 32'hFFFFFFFF);
      check("t6 rresp", r, ERR_EN ? 2'b10 : 2'b00);
      do_read(32'h0, d, r);
      check("t6 word0", d, ERR_EN ? 32'h0BADF00D : 32'hFFFFFFFF);

      // Randomised traffic with a mid-run reset.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst = 1; awvalid = 0; wvalid = 0; arvalid = 0;
            tick();
            tick();
            rst = 0;
         end
         tick();
         if (aw_f) awvalid = 0;
         if (w_f) wvalid = 0;
         if (ar_f) arvalid = 0;
         if (!awvalid && $urandom_range(0, 2) == 0) begin
            awvalid = 1; awaddr = rand_addr();
         end
         if (!wvalid && $urandom_range(0, 2) == 0) begin
            wvalid = 1; wdata = $urandom; wstrb = 4'($urandom_range(0, 15));
         end
         if (!arvalid && $urandom_range(0, 2) == 0) begin
            arvalid = 1; araddr = rand_addr();
         end
         bready = ($urandom_range(0, 3) != 0);
         rready = ($urandom_range(0, 3) != 0);
      end

      bready = 1; rready = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (aw_f) awvalid = 0;
         if (w_f) wvalid = 0;
         if (ar_f) arvalid = 0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
